// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU command sequencer and anything that talks
// to the registered ALU: datapath/opcode widths, the sequencer state
// encoding, and opcode constants used by benches and the control unit.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int ALU_W = 32;
   localparam int OP_W  = 4;

   // Sequencer states: waiting for a command, waiting out the ALU latency,
   // and presenting a captured result until the consumer takes it.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Opcode constants. The sequencer never decodes these; they exist so
   // benches and the control unit agree on the ALU's encoding.
   localparam logic [OP_W-1:0] OP_ADD  = 4'b0000;
   localparam logic [OP_W-1:0] OP_SUB  = 4'b0001;
   localparam logic [OP_W-1:0] OP_AND  = 4'b0010;
   localparam logic [OP_W-1:0] OP_OR   = 4'b0011;
   localparam logic [OP_W-1:0] OP_XOR  = 4'b0100;
   localparam logic [OP_W-1:0] OP_NOT  = 4'b0101;
   localparam logic [OP_W-1:0] OP_SHL  = 4'b0110;
   localparam logic [OP_W-1:0] OP_SHR  = 4'b0111;
   localparam logic [OP_W-1:0] OP_SAR  = 4'b1000;
   localparam logic [OP_W-1:0] OP_ROL  = 4'b1001;
   localparam logic [OP_W-1:0] OP_ROR  = 4'b1010;
   localparam logic [OP_W-1:0] OP_1011 = 4'b1011;

endpackage

// File: rtl/alu_seq_if.sv
// ---------------------------------------------------------------------------
// alu_seq_if
// Command and response channels of the ALU sequencer, both valid/ready.
//   cmd_valid/cmd_ready : command handshake
//   cmd_op/tr/sr/chain  : opcode, operands, "reuse last result as tr"
//   rsp_valid/rsp_ready : response handshake
//   rsp_dr/cf/of        : captured ALU result and flags
// Modports:
//   master : the command issuer / result consumer (control unit, bench)
//   slave  : the sequencer
// ---------------------------------------------------------------------------
interface alu_seq_if
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) ();

   logic            cmd_valid;
   logic            cmd_ready;
   logic [OP_W-1:0] cmd_op;
   logic [W-1:0]    cmd_tr;
   logic [W-1:0]    cmd_sr;
   logic            cmd_chain;

   logic            rsp_valid;
   logic            rsp_ready;
   logic [W-1:0]    rsp_dr;
   logic            rsp_cf;
   logic            rsp_of;

   modport master (
      output cmd_valid, cmd_op, cmd_tr, cmd_sr, cmd_chain, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_dr, rsp_cf, rsp_of
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_tr, cmd_sr, cmd_chain, rsp_ready,
      output cmd_ready, rsp_valid, rsp_dr, rsp_cf, rsp_of
   );

endinterface

// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq
// Command-side driver for the registered ALU. Takes one command at a time,
// drives the ALU operand ports and holds them, waits ALU_LAT edges, then
// captures dr/cf/of and offers them on the response channel. Supports
// chaining (last captured dr reused as tr) and a sticky overflow flag.
//
// Ports:
//   clk, rst_n      : clock (rising edge), async active-low reset
//   bus (slave)     : cmd_* / rsp_* valid/ready channels
//   alu_op/tr/sr    : operands to the ALU, change only on command accept
//   alu_dr/cf/of    : results from the ALU
//   sticky_of       : OR of all captured overflow flags since last clear
//   clr_sticky      : synchronous clear of sticky_of (a capture with of=1
//                     on the same edge wins)
//   busy            : high in any state other than IDLE
// ---------------------------------------------------------------------------
module alu_seq
   import alu_pkg::*;
#(
   parameter int W       = ALU_W,
   parameter int ALU_LAT = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_seq_if.slave        bus,
   output logic [OP_W-1:0] alu_op,
   output logic [W-1:0]    alu_tr,
   output logic [W-1:0]    alu_sr,
   input  logic [W-1:0]    alu_dr,
   input  logic            alu_cf,
   input  logic            alu_of,
   output logic            sticky_of,
   input  logic            clr_sticky,
   output logic            busy
);

   localparam int CW = $clog2(ALU_LAT + 1);

   state_t        state;
   state_t        next_state;
   logic          accept;
   logic          capture;
   logic [CW-1:0] cnt;
   logic [W-1:0]  prev_dr;
   logic [W-1:0]  rsp_dr_q;
   logic          rsp_cf_q;
   logic          rsp_of_q;

   // cmd_ready is qualified with rst_n so every output reads 0 while reset
   // is held, yet the block is ready as soon as reset is released.
   assign bus.cmd_ready = rst_n && (state == IDLE);
   assign bus.rsp_valid = (state == RESP);
   assign bus.rsp_dr    = rsp_dr_q;
   assign bus.rsp_cf    = rsp_cf_q;
   assign bus.rsp_of    = rsp_of_q;
   assign busy          = (state != IDLE);

   // State register. Reset drops straight back to IDLE from anywhere, which
   // throws away whatever the ALU was computing for the in-flight command.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic plus two strobes for the datapath: accept marks the
   // edge a command is taken, capture marks the edge the ALU outputs are
   // valid. Commands seen outside IDLE and rsp_ready outside RESP are simply
   // not looked at.
   always_comb begin
      next_state = state;
      accept     = 1'b0;
      capture    = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.cmd_valid) begin
               accept     = 1'b1;
               next_state = WAIT;
            end
         end
         WAIT: begin
            if (cnt == '0) begin
               capture    = 1'b1;
               next_state = RESP;
            end
         end
         RESP: begin
            if (bus.rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Operand registers and latency counter. The ALU inputs are written only
   // on the accept edge so the ALU sees perfectly stable operands for the
   // whole WAIT period and beyond. The counter is loaded with ALU_LAT and
   // capture happens on the edge it is already zero, i.e. ALU_LAT+1 edges
   // after accept: ALU_LAT edges for the ALU itself plus one to sample it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alu_op <= '0;
         alu_tr <= '0;
         alu_sr <= '0;
         cnt    <= '0;
      end else if (accept) begin
         alu_op <= bus.cmd_op;
         alu_sr <= bus.cmd_sr;
         alu_tr <= bus.cmd_chain ? prev_dr : bus.cmd_tr;
         cnt    <= CW'(ALU_LAT);
      end else if (state == WAIT && cnt != '0) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Result capture. prev_dr follows the captured dr only, so a chained
   // command always uses the last result actually returned (0 after reset).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_dr_q <= '0;
         rsp_cf_q <= 1'b0;
         rsp_of_q <= 1'b0;
         prev_dr  <= '0;
      end else if (capture) begin
         rsp_dr_q <= alu_dr;
         rsp_cf_q <= alu_cf;
         rsp_of_q <= alu_of;
         prev_dr  <= alu_dr;
      end
   end

   // Sticky overflow for the control unit. Setting takes priority over the
   // clear so an overflow arriving on the clear edge is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sticky_of <= 1'b0;
      end else if (capture && alu_of) begin
         sticky_of <= 1'b1;
      end else if (clr_sticky) begin
         sticky_of <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq
// Bench for alu_seq: one instance with ALU_LAT=1 exercised in depth and one
// with ALU_LAT=3 for latency/operand-hold, each beside a registered ALU
// model. Expected results are pushed to a queue as commands are accepted
// and popped when the response appears.
// ---------------------------------------------------------------------------
module tb_alu_seq;
   import alu_pkg::*;

   logic clk;
   logic rst_n;

   int total = 0;
   int bad   = 0;

   // Instance A: ALU_LAT = 1
   alu_seq_if #(.W(32)) ifa ();
   logic [3:0]  aluOpA;
   logic [31:0] aluTrA, aluSrA, aluDrA;
   logic        aluCfA, aluOfA;
   logic        stickyA, clrStickyA, busyA;

   // Instance B: ALU_LAT = 3
   alu_seq_if #(.W(32)) ifb ();
   logic [3:0]  aluOpB;
   logic [31:0] aluTrB, aluSrB, aluDrB;
   logic        aluCfB, aluOfB;
   logic        stickyB, clrStickyB, busyB;

   logic [33:0] pipeB1, pipeB2, pipeB3;

   logic [33:0] expQ[$];
   logic [31:0] modelPrev;
   logic        modelSticky;
   logic [31:0] lastTr;

   alu_seq #(.W(32), .ALU_LAT(1)) dutA (
      .clk(clk), .rst_n(rst_n), .bus(ifa),
      .alu_op(aluOpA), .alu_tr(aluTrA), .alu_sr(aluSrA),
      .alu_dr(aluDrA), .alu_cf(aluCfA), .alu_of(aluOfA),
      .sticky_of(stickyA), .clr_sticky(clrStickyA), .busy(busyA)
   );

   alu_seq #(.W(32), .ALU_LAT(3)) dutB (
      .clk(clk), .rst_n(rst_n), .bus(ifb),
      .alu_op(aluOpB), .alu_tr(aluTrB), .alu_sr(aluSrB),
      .alu_dr(aluDrB), .alu_cf(aluCfB), .alu_of(aluOfB),
      .sticky_of(stickyB), .clr_sticky(clrStickyB), .busy(busyB)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference ALU: returns {cf, of, dr}.
   function automatic logic [33:0] aluCalc(input logic [3:0] op,
                                           input logic [31:0] a,
                                           input logic [31:0] b);
      logic [32:0] s;
      logic [31:0] r;
      logic        cf;
      logic        of;
      s  = '0;
      r  = '0;
      cf = 1'b0;
      of = 1'b0;
      case (op)
         OP_ADD: begin
            s  = {1'b0, a} + {1'b0, b};
            r  = s[31:0];
            cf = s[32];
            of = (a[31] == b[31]) && (r[31] != a[31]);
         end
         OP_SUB: begin
            s  = {1'b0, a} - {1'b0, b};
            r  = s[31:0];
            cf = s[32];
            of = (a[31] != b[31]) && (r[31] != a[31]);
         end
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         default: r = ~a;
      endcase
      return {cf, of, r};
   endfunction

   // Registered ALU models sitting on each instance's operand ports.
   always_ff @(posedge clk) begin
      {aluCfA, aluOfA, aluDrA} <= aluCalc(aluOpA, aluTrA, aluSrA);
   end

   always_ff @(posedge clk) begin
      pipeB1 <= aluCalc(aluOpB, aluTrB, aluSrB);
      pipeB2 <= pipeB1;
      pipeB3 <= pipeB2;
   end
   assign {aluCfB, aluOfB, aluDrB} = pipeB3;

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      total++;
      if (observed !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Drive one command into instance A from a negedge; returns on the
   // negedge after the accept edge with the expectation queued.
   task automatic applyStimulus(input logic [3:0] op, input logic [31:0] tr,
                                input logic [31:0] sr, input logic chain);
      int n;
      logic [31:0] effTr;
      n = 0;
      while (!ifa.cmd_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!ifa.cmd_ready) begin
         checkOutput("cmd_ready_timeout", 64'(ifa.cmd_ready), 64'd1);
         return;
      end
      ifa.cmd_valid = 1'b1;
      ifa.cmd_op    = op;
      ifa.cmd_tr    = tr;
      ifa.cmd_sr    = sr;
      ifa.cmd_chain = chain;
      @(posedge clk);
      effTr  = chain ? modelPrev : tr;
      lastTr = effTr;
      expQ.push_back(aluCalc(op, effTr, sr));
      modelPrev = aluCalc(op, effTr, sr) & 34'h0FFFFFFFF;
      @(negedge clk);
      ifa.cmd_valid = 1'b0;
      ifa.cmd_chain = 1'b0;
      checkOutput("alu_tr", 64'(aluTrA), 64'(effTr));
      checkOutput("alu_sr", 64'(aluSrA), 64'(sr));
      checkOutput("alu_op", 64'(aluOpA), 64'(op));
      checkOutput("busy_wait", 64'(busyA), 64'd1);
      checkOutput("cmd_ready_wait", 64'(ifa.cmd_ready), 64'd0);
   endtask

   // Wait for instance A's response, compare against the queue head, then
   // optionally hold rsp_ready low for holdCycles before the handshake.
   task automatic awaitResponse(input bit clrAtCap, input int holdCycles);
      int i;
      logic [33:0] exp;
      i = 0;
      while (i < 20) begin
         @(negedge clk);
         i++;
         clrStickyA = 1'b0;
         if (ifa.rsp_valid) break;
         if (clrAtCap && i == 1) clrStickyA = 1'b1;
      end
      if (!ifa.rsp_valid) begin
         checkOutput("rsp_timeout", 64'(ifa.rsp_valid), 64'd1);
         return;
      end
      checkOutput("latency", 64'(i), 64'd2);
      if (expQ.size() == 0) begin
         checkOutput("queue_empty", 64'd0, 64'd1);
         return;
      end
      exp = expQ.pop_front();
      checkOutput("rsp_dr", 64'(ifa.rsp_dr), 64'(exp[31:0]));
      checkOutput("rsp_of", 64'(ifa.rsp_of), 64'(exp[32]));
      checkOutput("rsp_cf", 64'(ifa.rsp_cf), 64'(exp[33]));
      modelSticky = (clrAtCap ? 1'b0 : modelSticky) | exp[32];
      checkOutput("sticky_of", 64'(stickyA), 64'(modelSticky));
      for (int h = 0; h < holdCycles; h++) begin
         ifa.cmd_valid = h[0];
         ifa.cmd_tr    = 32'hDEAD0000 + 32'(h);
         ifa.cmd_sr    = 32'h1234;
         @(negedge clk);
         checkOutput("bp_rsp_valid", 64'(ifa.rsp_valid), 64'd1);
         checkOutput("bp_rsp_dr", 64'(ifa.rsp_dr), 64'(exp[31:0]));
         checkOutput("bp_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
         checkOutput("bp_alu_tr", 64'(aluTrA), 64'(lastTr));
      end
      ifa.cmd_valid = 1'b0;
      ifa.rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("rsp_valid_drop", 64'(ifa.rsp_valid), 64'd0);
      checkOutput("cmd_ready_idle", 64'(ifa.cmd_ready), 64'd1);
   endtask

   // Global time limit so the bench always ends.
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int     n;
      logic [33:0] expB;

      rst_n         = 1'b0;
      ifa.cmd_valid = 1'b0;
      ifa.cmd_op    = '0;
      ifa.cmd_tr    = '0;
      ifa.cmd_sr    = '0;
      ifa.cmd_chain = 1'b0;
      ifa.rsp_ready = 1'b1;
      ifb.cmd_valid = 1'b0;
      ifb.cmd_op    = '0;
      ifb.cmd_tr    = '0;
      ifb.cmd_sr    = '0;
      ifb.cmd_chain = 1'b0;
      ifb.rsp_ready = 1'b1;
      clrStickyA    = 1'b0;
      clrStickyB    = 1'b0;
      modelPrev     = '0;
      modelSticky   = 1'b0;
      lastTr        = '0;

      repeat (3) @(negedge clk);
      checkOutput("rst_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(ifa.rsp_valid), 64'd0);
      checkOutput("rst_busy", 64'(busyA), 64'd0);
      checkOutput("rst_sticky", 64'(stickyA), 64'd0);
      rst_n = 1'b1;
      @(negedge clk);
      checkOutput("post_rst_cmd_ready", 64'(ifa.cmd_ready), 64'd1);

      $display("[TB] first-after-reset chain");
      applyStimulus(OP_ADD, 32'd999, 32'd5, 1'b1);
      awaitResponse(1'b0, 0);

      $display("[TB] basic add and chain");
      applyStimulus(OP_ADD, 32'd32, 32'd21, 1'b0);
      awaitResponse(1'b0, 0);
      applyStimulus(OP_ADD, 32'd0, 32'd3, 1'b1);
      awaitResponse(1'b0, 0);

      $display("[TB] overflow and sticky");
      applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
      awaitResponse(1'b0, 0);
      applyStimulus(OP_ADD, 32'd5, 32'd6, 1'b0);
      awaitResponse(1'b0, 0);
      clrStickyA = 1'b1;
      @(negedge clk);
      clrStickyA  = 1'b0;
      modelSticky = 1'b0;
      checkOutput("sticky_cleared", 64'(stickyA), 64'd0);
      applyStimulus(OP_ADD, 32'h7FFFFFFF, 32'd1, 1'b0);
      awaitResponse(1'b1, 0);

      $display("[TB] mixed operations");
      applyStimulus(OP_SUB, 32'd5, 32'd7, 1'b0);
      awaitResponse(1'b0, 0);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(4'($urandom_range(0, 5)), $urandom, $urandom,
                       1'($urandom_range(0, 1)));
         awaitResponse(1'b0, 0);
      end

      $display("[TB] backpressure");
      ifa.rsp_ready = 1'b0;
      applyStimulus(OP_XOR, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0);
      awaitResponse(1'b0, 10);
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("bp_no_latch_busy", 64'(busyA), 64'd0);
      end

      $display("[TB] reset during WAIT");
      applyStimulus(OP_ADD, 32'd10, 32'd20, 1'b0);
      rst_n = 1'b0;
      #1;
      checkOutput("arst_busy", 64'(busyA), 64'd0);
      checkOutput("arst_alu_tr", 64'(aluTrA), 64'd0);
      checkOutput("arst_alu_sr", 64'(aluSrA), 64'd0);
      checkOutput("arst_cmd_ready", 64'(ifa.cmd_ready), 64'd0);
      checkOutput("arst_rsp_dr", 64'(ifa.rsp_dr), 64'd0);
      checkOutput("arst_sticky", 64'(stickyA), 64'd0);
      expQ.delete();
      modelPrev   = '0;
      modelSticky = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("no_stale_rsp", 64'(ifa.rsp_valid), 64'd0);
      end
      applyStimulus(OP_ADD, 32'd77, 32'd5, 1'b1);
      awaitResponse(1'b0, 0);

      $display("[TB] ALU_LAT=3 instance");
      @(negedge clk);
      ifb.cmd_valid = 1'b1;
      ifb.cmd_op    = OP_ADD;
      ifb.cmd_tr    = 32'd100;
      ifb.cmd_sr    = 32'd23;
      @(posedge clk);
      expB = aluCalc(OP_ADD, 32'd100, 32'd23);
      @(negedge clk);
      ifb.cmd_valid = 1'b0;
      n = 0;
      checkOutput("b_alu_tr_0", 64'(aluTrB), 64'd100);
      while (!ifb.rsp_valid && n < 20) begin
         @(negedge clk);
         n++;
         checkOutput("b_alu_tr_hold", 64'(aluTrB), 64'd100);
         checkOutput("b_alu_sr_hold", 64'(aluSrB), 64'd23);
      end
      checkOutput("b_latency", 64'(n), 64'd4);
      checkOutput("b_rsp_dr", 64'(ifb.rsp_dr), 64'(expB[31:0]));
      @(negedge clk);
      checkOutput("b_rsp_drop", 64'(ifb.rsp_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
